// File: rtl/rgb_bayer_mosaic_if.sv
// Stream bundle for rgb_bayer_mosaic: RGB pixel input side and Bayer raw output side.
// The master drives pixels and output-ready; the slave (the mosaic block) drives the rest.
interface rgb_bayer_mosaic_if;
  logic       IN_VALID;
  logic       IN_READY;
  logic       IN_SOF;
  logic       IN_EOL;
  logic [9:0] IN_R;
  logic [9:0] IN_G;
  logic [9:0] IN_B;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [9:0] OUT_D0;
  logic [9:0] OUT_D1;
  logic       OUT_X;
  logic       OUT_Y;
  logic       OUT_SOF;
  logic       OUT_EOL;

  modport master (
    output IN_VALID, IN_SOF, IN_EOL, IN_R, IN_G, IN_B, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_D0, OUT_D1, OUT_X, OUT_Y, OUT_SOF, OUT_EOL
  );

  modport slave (
    input  IN_VALID, IN_SOF, IN_EOL, IN_R, IN_G, IN_B, OUT_READY,
    output IN_READY, OUT_VALID, OUT_D0, OUT_D1, OUT_X, OUT_Y, OUT_SOF, OUT_EOL
  );
endinterface

// File: rtl/rgb_bayer_mosaic.sv
// RGB to Bayer mosaic with a one-line buffer: emits the current-line sample and the previous-line
// sample of the same column. Optional test pattern source under RGB_BAYER_MOSAIC_TESTPAT_EN.
module rgb_bayer_mosaic #(
  parameter int         MAX_WIDTH   = 1024,
  parameter int         COL_W       = 10,
  parameter logic [1:0] BAYER_PHASE = 2'b00
) (
  input  logic              CLK,
  input  logic              RESET_N,
`ifdef RGB_BAYER_MOSAIC_TESTPAT_EN
  input  logic              TP_EN,
`endif
  rgb_bayer_mosaic_if.slave bus,
  output logic              ERR_OVF
);

  typedef enum logic [1:0] {
    SITE_R   = 2'b00,
    SITE_G_R = 2'b01,
    SITE_G_B = 2'b10,
    SITE_B   = 2'b11
  } site_e;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAX_WIDTH - 1);

  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_eff;
  logic [15:0]      row;
  logic [15:0]      row_eff;
  logic             line_valid;
  logic             lv_eff;
  logic             xfer_in;
  logic             ovf_hit;
  logic [9:0]       r_src;
  logic [9:0]       g_src;
  logic [9:0]       b_src;
  logic [9:0]       d0_next;
  logic [9:0]       ram_q;
  logic             d1_en;
  site_e            site;
  logic [9:0]       line_mem [0:MAX_WIDTH-1];

  // A single output register: input may advance whenever that register is empty or draining.
  assign bus.IN_READY = !bus.OUT_VALID || bus.OUT_READY;
  assign xfer_in      = bus.IN_VALID && bus.IN_READY;

  // SOF restarts the frame on this very pixel, so it is positioned at column 0 of row 0.
  assign col_eff = bus.IN_SOF ? '0 : col;
  assign row_eff = bus.IN_SOF ? '0 : row;
  assign lv_eff  = bus.IN_SOF ? 1'b0 : line_valid;
  assign ovf_hit = (col_eff == COL_LAST) && !bus.IN_EOL;

`ifdef RGB_BAYER_MOSAIC_TESTPAT_EN
  assign r_src = TP_EN ? 10'(col_eff)  : bus.IN_R;
  assign g_src = TP_EN ? row_eff[9:0]  : bus.IN_G;
  assign b_src = TP_EN ? ~10'(col_eff) : bus.IN_B;
`else
  assign r_src = bus.IN_R;
  assign g_src = bus.IN_G;
  assign b_src = bus.IN_B;
`endif

  always_comb begin
    // NOTE: d0_next gets a default before the case so every path assigns it and no latch is inferred.
    d0_next = g_src;
    site    = site_e'({row_eff[0], col_eff[0]} ^ BAYER_PHASE);
    case (site)
      SITE_R:  d0_next = r_src;
      SITE_B:  d0_next = b_src;
      default: d0_next = g_src;
    endcase
  end

  // Read-before-write: ram_q captures the previous line's entry while the new sample replaces it.
  // NOTE: the line memory has no reset so it maps onto plain RAM; stale contents are masked by d1_en.
  always_ff @(posedge CLK) begin
    if (xfer_in) begin
      ram_q             <= line_mem[col_eff];
      line_mem[col_eff] <= d0_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      col        <= '0;
      row        <= '0;
      line_valid <= 1'b0;
      ERR_OVF    <= 1'b0;
    end else if (xfer_in) begin
      ERR_OVF <= (ERR_OVF && !bus.IN_SOF) || ovf_hit;
      if (bus.IN_EOL) begin
        col        <= '0;
        row        <= row_eff + 16'd1;
        line_valid <= 1'b1;
      end else begin
        // An overlong line parks on the last column and keeps overwriting that entry.
        col        <= ovf_hit ? COL_LAST : col_eff + COL_W'(1);
        row        <= row_eff;
        line_valid <= lv_eff;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bus.OUT_VALID <= 1'b0;
      bus.OUT_D0    <= '0;
      bus.OUT_X     <= 1'b0;
      bus.OUT_Y     <= 1'b0;
      bus.OUT_SOF   <= 1'b0;
      bus.OUT_EOL   <= 1'b0;
      d1_en         <= 1'b0;
    end else if (xfer_in) begin
      bus.OUT_VALID <= 1'b1;
      bus.OUT_D0    <= d0_next;
      bus.OUT_X     <= col_eff[0];
      bus.OUT_Y     <= row_eff[0];
      bus.OUT_SOF   <= bus.IN_SOF;
      bus.OUT_EOL   <= bus.IN_EOL;
      d1_en         <= lv_eff;
    end else if (bus.OUT_READY) begin
      bus.OUT_VALID <= 1'b0;
    end
  end

  // The RAM read register is the D1 half of the output stage; d1_en blanks it on a frame's first line.
  assign bus.OUT_D1 = d1_en ? ram_q : '0;

endmodule

// File: tb/tb_rgb_bayer_mosaic.sv
// Bench for rgb_bayer_mosaic: two instances (phase 00 and 11, 8-pixel line buffer) share one stimulus
// stream; a frame-level model predicts each output sample and a compare process checks every cycle.
module tb_rgb_bayer_mosaic;
  localparam int MW = 8;

  typedef struct {
    logic [9:0] d0a;
    logic [9:0] d0b;
    logic [9:0] d1a;
    logic [9:0] d1b;
    logic       x;
    logic       y;
    logic       sof;
    logic       eol;
    logic       ovf;
    time        t;
  } smp_t;

  logic       CLK     = 1'b0;
  logic       RESET_N = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof   = 1'b0;
  logic       in_eol   = 1'b0;
  logic       out_ready = 1'b1;
  logic [9:0] in_r = '0;
  logic [9:0] in_g = '0;
  logic [9:0] in_b = '0;
`ifdef RGB_BAYER_MOSAIC_TESTPAT_EN
  logic       tp_en = 1'b0;
`endif
  logic       err_a;
  logic       err_b;

  always #5 CLK = ~CLK;

  rgb_bayer_mosaic_if bus_a ();
  rgb_bayer_mosaic_if bus_b ();

  assign bus_a.IN_VALID = in_valid;
  assign bus_a.IN_SOF   = in_sof;
  assign bus_a.IN_EOL   = in_eol;
  assign bus_a.IN_R     = in_r;
  assign bus_a.IN_G     = in_g;
  assign bus_a.IN_B     = in_b;
  assign bus_a.OUT_READY = out_ready;
  assign bus_b.IN_VALID = in_valid;
  assign bus_b.IN_SOF   = in_sof;
  assign bus_b.IN_EOL   = in_eol;
  assign bus_b.IN_R     = in_r;
  assign bus_b.IN_G     = in_g;
  assign bus_b.IN_B     = in_b;
  assign bus_b.OUT_READY = out_ready;

  rgb_bayer_mosaic #(.MAX_WIDTH(MW), .COL_W(3), .BAYER_PHASE(2'b00)) dut_a (
    .CLK     (CLK),
    .RESET_N (RESET_N),
`ifdef RGB_BAYER_MOSAIC_TESTPAT_EN
    .TP_EN   (tp_en),
`endif
    .bus     (bus_a),
    .ERR_OVF (err_a)
  );

  rgb_bayer_mosaic #(.MAX_WIDTH(MW), .COL_W(3), .BAYER_PHASE(2'b11)) dut_b (
    .CLK     (CLK),
    .RESET_N (RESET_N),
`ifdef RGB_BAYER_MOSAIC_TESTPAT_EN
    .TP_EN   (tp_en),
`endif
    .bus     (bus_b),
    .ERR_OVF (err_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int stall_req = 0;
  int stall_cycles = 0;

  // Frame model state: pixels so far in the line, line number, previous-line availability.
  int         m_cnt = 0;
  int         m_row = 0;
  bit         m_lv  = 1'b0;
  bit         m_ovf = 1'b0;
  logic [9:0] mem_a [MW];
  logic [9:0] mem_b [MW];
  smp_t       exp_q [$];
  smp_t       obs_q [$];

  int l0a [4] = '{100, 200, 100, 200};
  int l1a [4] = '{200, 300, 200, 300};
  int l0b [4] = '{300, 200, 300, 200};
  int l1b [4] = '{200, 100, 200, 100};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] pick(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                                      input int yy, input int xx, input int ph);
    int s;
    s = ((yy % 2) * 2 + (xx % 2)) ^ ph;
    if (s == 0) return r;
    if (s == 3) return b;
    return g;
  endfunction

  task automatic model_accept();
    smp_t       e;
    int         col;
    logic [2:0] ci;
    logic [9:0] r, g, b;
    r = in_r;
    g = in_g;
    b = in_b;
    if (in_sof) begin
      m_cnt = 0;
      m_row = 0;
      m_lv  = 1'b0;
      m_ovf = 1'b0;
    end
    col = (m_cnt > MW - 1) ? MW - 1 : m_cnt;
    ci  = 3'(col);
`ifdef RGB_BAYER_MOSAIC_TESTPAT_EN
    if (tp_en) begin
      r = 10'(col);
      g = 10'(m_row % 1024);
      b = ~10'(col);
    end
`endif
    e.d0a = pick(r, g, b, m_row, col, 0);
    e.d0b = pick(r, g, b, m_row, col, 3);
    e.d1a = m_lv ? mem_a[ci] : 10'd0;
    e.d1b = m_lv ? mem_b[ci] : 10'd0;
    mem_a[ci] = e.d0a;
    mem_b[ci] = e.d0b;
    if (col == MW - 1 && !in_eol) m_ovf = 1'b1;
    e.ovf = m_ovf;
    e.x   = 1'(col % 2);
    e.y   = 1'(m_row % 2);
    e.sof = in_sof;
    e.eol = in_eol;
    e.t   = $time;
    exp_q.push_back(e);
    if (in_eol) begin
      m_cnt = 0;
      m_row = m_row + 1;
      m_lv  = 1'b1;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic send(input int v_r, input int v_g, input int v_b, input bit sof, input bit eol);
    int guard = 0;
    @(negedge CLK);
    in_valid = 1'b1;
    in_r = 10'(v_r);
    in_g = 10'(v_g);
    in_b = 10'(v_b);
    in_sof = sof;
    in_eol = eol;
    #1;
    while (!bus_a.IN_READY && guard < 50) begin
      @(negedge CLK);
      #1;
      guard++;
    end
    if (!bus_a.IN_READY) begin
      check("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      model_accept();
    end
    @(posedge CLK);
  endtask

  task automatic idle();
    @(negedge CLK);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    idle();
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic send_frame_4x2();
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 4; c++) begin
        if (l == 0 && c == 2 && stall_req < 0) stall_req = 3;
        send(100, 200, 300, (l == 0 && c == 0), (c == 3));
      end
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_count"}, obs_q.size(), 8);
    if (obs_q.size() == 8) begin
      for (int i = 0; i < 4; i++) begin
        check({tag, "_l0_d0a"}, int'(obs_q[i].d0a), l0a[i]);
        check({tag, "_l0_d0b"}, int'(obs_q[i].d0b), l0b[i]);
        check({tag, "_l0_d1a"}, int'(obs_q[i].d1a), 0);
        check({tag, "_l0_x"}, int'(obs_q[i].x), i % 2);
        check({tag, "_l0_y"}, int'(obs_q[i].y), 0);
        check({tag, "_l1_d0a"}, int'(obs_q[4+i].d0a), l1a[i]);
        check({tag, "_l1_d0b"}, int'(obs_q[4+i].d0b), l1b[i]);
        check({tag, "_l1_d1a"}, int'(obs_q[4+i].d1a), l0a[i]);
        check({tag, "_l1_d1b"}, int'(obs_q[4+i].d1b), l0b[i]);
        check({tag, "_l1_y"}, int'(obs_q[4+i].y), 1);
      end
    end
  endtask

  // Stall control: a pending request pulls OUT_READY low for that many cycles.
  always @(negedge CLK) begin
    if (stall_req > 0) begin
      out_ready = 1'b0;
      stall_req = stall_req - 1;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Compare process: runs late in the low phase, when the coming edge's handshake is already settled.
  initial begin
    forever begin
      @(negedge CLK);
      #3;
      if (RESET_N) begin : cmp
        bit   ev;
        smp_t e;
        smp_t o;
        ev = (exp_q.size() > 0) && (exp_q[0].t + 2 < $time);
        check("in_ready", int'(bus_a.IN_READY), int'(!bus_a.OUT_VALID || out_ready));
        check("out_valid_a", int'(bus_a.OUT_VALID), int'(ev));
        check("out_valid_b", int'(bus_b.OUT_VALID), int'(ev));
        if (bus_a.OUT_VALID && !out_ready) stall_cycles++;
        if (ev) begin
          e = exp_q[0];
          check("d0_a", int'(bus_a.OUT_D0), int'(e.d0a));
          check("d0_b", int'(bus_b.OUT_D0), int'(e.d0b));
          check("d1_a", int'(bus_a.OUT_D1), int'(e.d1a));
          check("d1_b", int'(bus_b.OUT_D1), int'(e.d1b));
          check("x", int'(bus_a.OUT_X), int'(e.x));
          check("y", int'(bus_b.OUT_Y), int'(e.y));
          check("sof", int'(bus_a.OUT_SOF), int'(e.sof));
          check("eol", int'(bus_b.OUT_EOL), int'(e.eol));
          check("err_ovf_a", int'(err_a), int'(e.ovf));
          check("err_ovf_b", int'(err_b), int'(e.ovf));
          if (out_ready) begin
            o = e;
            o.d0a = bus_a.OUT_D0;
            o.d0b = bus_b.OUT_D0;
            o.d1a = bus_a.OUT_D1;
            o.d1b = bus_b.OUT_D1;
            o.x   = bus_a.OUT_X;
            o.y   = bus_a.OUT_Y;
            obs_q.push_back(o);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, held asynchronously before any clock edge.
    #12;
    check("rst_out_valid", int'(bus_a.OUT_VALID), 0);
    check("rst_d0", int'(bus_a.OUT_D0), 0);
    check("rst_d1", int'(bus_a.OUT_D1), 0);
    check("rst_err", int'(err_a), 0);
    check("rst_in_ready", int'(bus_a.IN_READY), 1);
    RESET_N = 1'b1;

    // 4x2 constant-colour frame at full throughput, both phases.
    obs_q.delete();
    send_frame_4x2();
    drain();
    check_frame("flat");

    // Same frame with OUT_READY low for three cycles mid-line.
    obs_q.delete();
    stall_cycles = 0;
    stall_req = -1;
    send_frame_4x2();
    drain();
    check("stall_cycles", stall_cycles, 3);
    check_frame("stall");

    // Overflow: ten pixels into an eight-entry line, then a full line reading it back.
    obs_q.delete();
    for (int i = 0; i < 10; i++) begin
      send(50 + i, 50 + i, 50 + i, (i == 0), (i == 9));
      #2;
      if (i == 6) check("ovf_before", int'(err_a), 0);
      if (i == 8) check("ovf_after_9th", int'(err_a), 1);
    end
    for (int i = 0; i < 8; i++) send(i, i, i, 1'b0, (i == 7));
    drain();
    check("ovf_count", obs_q.size(), 18);
    if (obs_q.size() == 18) begin
      check("ovf_x_held", int'(obs_q[9].x), 1);
      check("ovf_d1a_col6", int'(obs_q[16].d1a), 56);
      check("ovf_d1a_col7", int'(obs_q[17].d1a), 59);
      check("ovf_d1b_col7", int'(obs_q[17].d1b), 59);
    end
    check("ovf_sticky", int'(err_a), 1);

    // SOF arriving at column 2 of line 1 restarts the frame.
    obs_q.delete();
    for (int c = 0; c < 4; c++) begin
      send(10 + c, 10 + c, 10 + c, (c == 0), (c == 3));
      if (c == 0) begin
        #2;
        check("ovf_clear_on_sof", int'(err_a), 0);
      end
    end
    for (int c = 0; c < 2; c++) send(20 + c, 20 + c, 20 + c, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) send(30 + c, 30 + c, 30 + c, (c == 0), (c == 3));
    drain();
    check("sof_count", obs_q.size(), 10);
    if (obs_q.size() == 10) begin
      check("sof_line1_y", int'(obs_q[4].y), 1);
      check("sof_line1_d1", int'(obs_q[5].d1a), 11);
      check("sof_new_d0", int'(obs_q[6].d0a), 30);
      for (int i = 6; i < 10; i++) begin
        check("sof_new_y", int'(obs_q[i].y), 0);
        check("sof_new_x", int'(obs_q[i].x), (i - 6) % 2);
        check("sof_new_d1a", int'(obs_q[i].d1a), 0);
        check("sof_new_d1b", int'(obs_q[i].d1b), 0);
      end
    end

    // Asynchronous reset in the middle of a line after an overflow.
    for (int i = 0; i < 10; i++) send(70 + i, 70 + i, 70 + i, 1'b0, (i == 9));
    for (int c = 0; c < 2; c++) send(80 + c, 80 + c, 80 + c, 1'b0, 1'b0);
    #2;
    check("pre_rst_err", int'(err_a), 1);
    check("pre_rst_valid", int'(bus_a.OUT_VALID), 1);
    RESET_N  = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    m_row = 0;
    m_lv  = 1'b0;
    m_ovf = 1'b0;
    #1;
    check("arst_valid", int'(bus_a.OUT_VALID), 0);
    check("arst_d0", int'(bus_a.OUT_D0), 0);
    check("arst_d1", int'(bus_a.OUT_D1), 0);
    check("arst_err", int'(err_a), 0);
    @(negedge CLK);
    #1;
    RESET_N = 1'b1;
    obs_q.delete();
    for (int c = 0; c < 2; c++) send(90 + c, 90 + c, 90 + c, 1'b0, 1'b0);
    drain();
    check("post_rst_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("post_rst_x", int'(obs_q[0].x), 0);
      check("post_rst_y", int'(obs_q[0].y), 0);
      check("post_rst_d1", int'(obs_q[0].d1a), 0);
      check("post_rst_d0", int'(obs_q[0].d0a), 90);
      check("post_rst_x1", int'(obs_q[1].x), 1);
    end

`ifdef RGB_BAYER_MOSAIC_TESTPAT_EN
    // Test pattern on line 0: R sites carry the column, G sites the row.
    tp_en = 1'b1;
    obs_q.delete();
    for (int c = 0; c < 6; c++) send(999, 999, 999, (c == 0), (c == 5));
    drain();
    tp_en = 1'b0;
    check("tp_count", obs_q.size(), 6);
    if (obs_q.size() == 6) begin
      check("tp_col4", int'(obs_q[4].d0a), 4);
      check("tp_col5", int'(obs_q[5].d0a), 0);
      check("tp_col4_b", int'(obs_q[4].d0b), 1019);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
